mem_writeback: RTL
==================

Name: mem_writeback

Overview:
Stage directly downstream of the ALU. It consumes the ALU result, flag and destination register number, and performs load/store memory access with a timeout. It retires each instruction as a register-file write, a flag update, a destination-pointer update or a branch redirect. It owns the architectural flag register (feeds ALU C_IN) and the current destination-register pointer (feeds ALU REG_NUM).

Parameters:
MEM_TIMEOUT, 15, max cycles waiting for MEM_ACK before abort; 0 disables timeout
REG_W, 4, destination register number width
DATA_W, 8, datapath width

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET_N  in  1  asynchronous active-low reset
EX_VALID  in  1  ALU outputs valid this cycle
EX_READY  out  1  stage can accept; transfer = EX_VALID & EX_READY
EX_OP  in  5  opcode (definitions package encoding)
EX_RESULT  in  8  ALU OUT
EX_FLAG  in  1  ALU FLAG_OUT
EX_REG_NUM  in  4  ALU REG_NUM_OUT
EX_STORE_DATA  in  8  register value to store
MEM_REQ  out  1  memory request, held until ack or abort
MEM_WE  out  1  1 = store, 0 = load; valid with MEM_REQ
MEM_ADDR  out  8  address (EX_RESULT captured at accept)
MEM_WDATA  out  8  store data
MEM_RDATA  in  8  load data, valid with MEM_ACK
MEM_ACK  in  1  one-cycle completion strobe
WB_WE  out  1  register-file write strobe, one cycle
WB_REG  out  4  write register index
WB_DATA  out  8  write data
FLAG_Q  out  1  architectural flag
DEST_REG_Q  out  4  current destination pointer
BRANCH_TAKEN  out  1  one-cycle redirect pulse
BRANCH_TARGET  out  8  redirect address
MEM_ERR  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, RESET_N=0):
  - All outputs are 0, state S_IDLE, timeout counter 0.
  - Reset during S_MEM drops MEM_REQ immediately; the access is discarded.
- States:
  - S_IDLE: EX_READY=1.
  - S_MEM: EX_READY=0, MEM_REQ=1.
- Op classes:
  - Reg-write ops: Add, Addc, Sub, Incr, Decr, MovImm, MovReg, Clr, Shl, Shr, Sar, Rcr, Rcl, And, Xor, Max.
  - Flag-only ops: CmpImm, CmpReg, Clfb, Ckfr.
  - Memory ops: LoadImm, LoadReg, StoreImm, StoreReg.
  - Branch ops: Jmp, Jz, Jnz, Jfnz.
  - Pointer op: Setdr.
- Non-memory transfer in S_IDLE, 1-cycle latency (outputs registered):
  - FLAG_Q <= EX_FLAG for all non-memory ops.
  - Reg-write ops: WB_WE=1, WB_REG=EX_REG_NUM, WB_DATA=EX_RESULT.
  - Setdr: DEST_REG_Q <= EX_REG_NUM; no WB write.
  - Branch ops: Jmp is always taken. Jz, Jnz and Jfnz are taken iff EX_RESULT != 0; address 0 is the not-taken encoding. When taken, BRANCH_TAKEN=1 and BRANCH_TARGET=EX_RESULT.
  - Undefined opcode: retire with no effect.
- Memory transfer:
  - Capture MEM_ADDR=EX_RESULT, MEM_WDATA=EX_STORE_DATA, MEM_WE=store, and the destination register; enter S_MEM.
  - MEM_REQ rises the cycle after accept. FLAG_Q is unchanged.
- S_MEM:
  - Counter increments each cycle MEM_ACK=0.
  - On MEM_ACK: a load writes WB_WE=1, WB_REG=captured reg, WB_DATA=MEM_RDATA next cycle; a store writes nothing. MEM_REQ drops, return to S_IDLE.
  - Counter reaching MEM_TIMEOUT (MEM_TIMEOUT≠0): MEM_ERR pulse, no write, MEM_REQ drops, return to S_IDLE.
  - MEM_ACK on the timeout cycle: ack wins, no MEM_ERR.
- Boundaries:
  - MEM_ACK in S_IDLE is ignored.
  - EX_VALID during S_MEM is not accepted; upstream holds its inputs.
  - Back-to-back non-memory ops are accepted every cycle.
  - Counter width is $clog2(MEM_TIMEOUT+1).

Optional Feature:
RETIRE_CNT_EN
- Defined: adds output RETIRE_CNT [15:0], reset 0. Increments once per retired instruction: non-memory transfer, or memory ack. Wraps 0xFFFF→0. Timeout aborts do not count.
- Undefined: no port and no counter logic.

Decomposition:
- definitions package: wb_state_t enum {S_IDLE, S_MEM}; functions is_reg_write(op), is_flag_only(op), is_mem(op), is_store(op), is_branch(op); constant MEM_TIMEOUT_DEF=15.
- One sub-module, wb_mem_ctrl: MEM_REQ hold, timeout counter, ack/abort result.

Test Plan:
- Add retire: EX_OP=opAdd, EX_RESULT=0x3C, EX_FLAG=1, EX_REG_NUM=5 → next cycle WB_WE=1, WB_REG=5, WB_DATA=0x3C, FLAG_Q=1.
- Setdr then CmpReg: Setdr with EX_REG_NUM=9 → DEST_REG_Q=9, WB_WE=0. Then CmpReg with EX_FLAG=0 → FLAG_Q=0, no write.
- Load with ack after 3 cycles: LoadImm, EX_RESULT=0x42, reg 2; MEM_RDATA=0xA5 → MEM_REQ high 3 cycles, MEM_ADDR=0x42, EX_READY=0 throughout, then WB_WE=1, WB_REG=2, WB_DATA=0xA5.
- Store timeout: StoreReg, no MEM_ACK → MEM_WE=1, MEM_REQ high 15 cycles, MEM_ERR pulse, no WB write, EX_READY=1 next cycle. Repeat with ack on cycle 15 → no MEM_ERR.
- Branches: Jz with EX_RESULT=0x00 → BRANCH_TAKEN=0. Jnz with 0x27 → BRANCH_TAKEN=1, BRANCH_TARGET=0x27. Jmp with 0x10 → taken.
- Reset mid-load: RESET_N=0 while MEM_REQ=1 → MEM_REQ=0 immediately, all outputs 0. After release, MEM_ACK=1 is ignored and there is no WB write.

Source files
------------

// File: rtl/mem_writeback_pkg.sv
// rtl/mem_writeback_pkg.sv - opcode encoding, stage state type and op-class helpers
package mem_writeback_pkg;

   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int OP_W            = 5;

   typedef enum logic {S_IDLE, S_MEM} wb_state_t;

   // Codes are grouped by class so each helper is a range test; 29..31 are undefined.
   localparam logic [OP_W-1:0] OP_ADD      = 5'd0;
   localparam logic [OP_W-1:0] OP_ADDC     = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB      = 5'd2;
   localparam logic [OP_W-1:0] OP_INCR     = 5'd3;
   localparam logic [OP_W-1:0] OP_DECR     = 5'd4;
   localparam logic [OP_W-1:0] OP_MOVIMM   = 5'd5;
   localparam logic [OP_W-1:0] OP_MOVREG   = 5'd6;
   localparam logic [OP_W-1:0] OP_CLR      = 5'd7;
   localparam logic [OP_W-1:0] OP_SHL      = 5'd8;
   localparam logic [OP_W-1:0] OP_SHR      = 5'd9;
   localparam logic [OP_W-1:0] OP_SAR      = 5'd10;
   localparam logic [OP_W-1:0] OP_RCR      = 5'd11;
   localparam logic [OP_W-1:0] OP_RCL      = 5'd12;
   localparam logic [OP_W-1:0] OP_AND      = 5'd13;
   localparam logic [OP_W-1:0] OP_XOR      = 5'd14;
   localparam logic [OP_W-1:0] OP_MAX      = 5'd15;
   localparam logic [OP_W-1:0] OP_CMPIMM   = 5'd16;
   localparam logic [OP_W-1:0] OP_CMPREG   = 5'd17;
   localparam logic [OP_W-1:0] OP_CLFB     = 5'd18;
   localparam logic [OP_W-1:0] OP_CKFR     = 5'd19;
   localparam logic [OP_W-1:0] OP_LOADIMM  = 5'd20;
   localparam logic [OP_W-1:0] OP_LOADREG  = 5'd21;
   localparam logic [OP_W-1:0] OP_STOREIMM = 5'd22;
   localparam logic [OP_W-1:0] OP_STOREREG = 5'd23;
   localparam logic [OP_W-1:0] OP_JMP      = 5'd24;
   localparam logic [OP_W-1:0] OP_JZ       = 5'd25;
   localparam logic [OP_W-1:0] OP_JNZ      = 5'd26;
   localparam logic [OP_W-1:0] OP_JFNZ     = 5'd27;
   localparam logic [OP_W-1:0] OP_SETDR    = 5'd28;

   function automatic logic is_reg_write(input logic [OP_W-1:0] op);
      return op <= OP_MAX;
   endfunction

   function automatic logic is_flag_only(input logic [OP_W-1:0] op);
      return (op >= OP_CMPIMM) && (op <= OP_CKFR);
   endfunction

   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return (op >= OP_LOADIMM) && (op <= OP_STOREREG);
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return (op == OP_STOREIMM) || (op == OP_STOREREG);
   endfunction

   function automatic logic is_branch(input logic [OP_W-1:0] op);
      return (op >= OP_JMP) && (op <= OP_JFNZ);
   endfunction

   function automatic logic is_defined(input logic [OP_W-1:0] op);
      return op <= OP_SETDR;
   endfunction

endpackage

// File: rtl/mem_writeback_if.sv
// rtl/mem_writeback_if.sv - ALU-side handshake and memory bus seen by the writeback stage
interface mem_writeback_if #(
   parameter int REG_W  = 4,
   parameter int DATA_W = 8
);
   logic              ex_valid;
   logic              ex_ready;
   logic [4:0]        ex_op;
   logic [DATA_W-1:0] ex_result;
   logic              ex_flag;
   logic [REG_W-1:0]  ex_reg_num;
   logic [DATA_W-1:0] ex_store_data;

   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   // master: the surrounding ALU + memory; slave: the writeback stage
   modport master (
      output ex_valid, ex_op, ex_result, ex_flag, ex_reg_num, ex_store_data,
      output mem_rdata, mem_ack,
      input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  ex_valid, ex_op, ex_result, ex_flag, ex_reg_num, ex_store_data,
      input  mem_rdata, mem_ack,
      output ex_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/wb_mem_ctrl.sv
// rtl/wb_mem_ctrl.sv - memory request hold, timeout counter and ack/abort resolution
module wb_mem_ctrl #(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic mem_ack,
   output logic req,
   output logic ack_done,
   output logic abort
);
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic          req_q;
   logic [CW-1:0] cnt_q;

   assign req      = req_q;
   assign ack_done = req_q & mem_ack;
   // Abort on the edge the counter would reach MEM_TIMEOUT; an ack on that cycle wins.
   assign abort    = req_q & ~mem_ack & (MEM_TIMEOUT != 0) & (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         req_q <= 1'b1;
         cnt_q <= '0;
      end else if (ack_done || abort) begin
         req_q <= 1'b0;
         cnt_q <= '0;
      end else if (req_q) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - writeback/memory stage top; optional RETIRE_CNT_EN adds a retire counter
module mem_writeback
   import mem_writeback_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int REG_W       = 4,
   parameter int DATA_W      = 8
)(
   input  logic              clk,
   input  logic              reset_n,
   mem_writeback_if.slave    bus,
   output logic              wb_we,
   output logic [REG_W-1:0]  wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              flag_q,
   output logic [REG_W-1:0]  dest_reg_q,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              mem_err
`ifdef RETIRE_CNT_EN
   ,output logic [15:0]      retire_cnt
`endif
);
   wb_state_t         state_q, state_d;
   logic              ready_q;
   logic              accept, start;
   logic              ack_done, abort, req;
   logic              we_q;
   logic [DATA_W-1:0] addr_q, wdata_q;
   logic [REG_W-1:0]  cap_reg_q;

   assign bus.ex_ready  = ready_q;
   assign bus.mem_req   = req;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   wb_mem_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_ctrl (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .mem_ack  (bus.mem_ack),
      .req      (req),
      .ack_done (ack_done),
      .abort    (abort)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            accept = bus.ex_valid & ready_q;
            if (accept && is_mem(bus.ex_op)) begin
               start   = 1'b1;
               state_d = S_MEM;
            end
         end
         S_MEM: begin
            if (ack_done || abort) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ready is registered so it reads 0 while reset is asserted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q       <= 1'b0;
         wb_we         <= 1'b0;
         wb_reg        <= '0;
         wb_data       <= '0;
         flag_q        <= 1'b0;
         dest_reg_q    <= '0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
         mem_err       <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cap_reg_q     <= '0;
      end else begin
         ready_q      <= (state_d == S_IDLE);
         wb_we        <= 1'b0;
         branch_taken <= 1'b0;
         mem_err      <= abort;
         if (accept) begin
            if (is_mem(bus.ex_op)) begin
               we_q      <= is_store(bus.ex_op);
               addr_q    <= bus.ex_result;
               wdata_q   <= bus.ex_store_data;
               cap_reg_q <= bus.ex_reg_num;
            end else if (is_defined(bus.ex_op)) begin
               flag_q <= bus.ex_flag;
               if (is_reg_write(bus.ex_op)) begin
                  wb_we   <= 1'b1;
                  wb_reg  <= bus.ex_reg_num;
                  wb_data <= bus.ex_result;
               end
               if (bus.ex_op == OP_SETDR) dest_reg_q <= bus.ex_reg_num;
               // A zero target doubles as the not-taken encoding for conditional branches.
               if (is_branch(bus.ex_op) &&
                   ((bus.ex_op == OP_JMP) || (bus.ex_result != '0))) begin
                  branch_taken  <= 1'b1;
                  branch_target <= bus.ex_result;
               end
            end
         end
         if (ack_done && !we_q) begin
            wb_we   <= 1'b1;
            wb_reg  <= cap_reg_q;
            wb_data <= bus.mem_rdata;
         end
      end
   end

`ifdef RETIRE_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         retire_cnt <= '0;
      else if ((accept && !is_mem(bus.ex_op)) || ack_done)
         retire_cnt <= retire_cnt + 16'd1;
   end
`endif
endmodule
